// File: rtl/key4_onehot_capture_pkg.sv
// Shared definitions for the four-key one-hot capture block.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package key4_onehot_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   localparam logic [3:0] OH_K0   = 4'b0001;
   localparam logic [3:0] OH_K1   = 4'b0010;
   localparam logic [3:0] OH_K2   = 4'b0100;
   localparam logic [3:0] OH_K3   = 4'b1000;
   localparam logic [1:0] CODE_K0 = 2'b00;
   localparam logic [1:0] CODE_K1 = 2'b01;
   localparam logic [1:0] CODE_K2 = 2'b10;
   localparam logic [1:0] CODE_K3 = 2'b11;

   // Isolate the lowest set bit so that simultaneous presses resolve to the lowest key.
   function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
      return v & (~v + 4'd1);
   endfunction

   // 4-to-2 encoder; anything that is not a clean one-hot encodes as 00.
   function automatic logic [1:0] onehot_to_code(input logic [3:0] oh);
      logic [1:0] c;
      c = 2'b00;
      case (oh)
         OH_K0:   c = CODE_K0;
         OH_K1:   c = CODE_K1;
         OH_K2:   c = CODE_K2;
         OH_K3:   c = CODE_K3;
         default: c = 2'b00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/key4_onehot_capture_key_debounce.sv
// Per-key 2-flop synchronizer plus counter debouncer with a registered press pulse.
// Latency: raw edge -> level/press = 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; free-running, press is a single-cycle pulse.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic level,
   output logic press
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // Count consecutive samples that disagree with the debounced level; flip after enough.
   always_comb begin
      sync1_d = key_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            press_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/key4_onehot_capture.sv
// Debounces four keys and presents one press at a time as onehot/code (optional multi_err via KEY4_CAPTURE_MULTI_ERR_EN).
// Latency: raw edge -> valid = 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: event held stable until ready; presses while held or before all keys release are dropped.
module key4_onehot_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_raw,
   input  logic       ready,
   output logic       valid,
   output logic [3:0] onehot,
   output logic [1:0] code,
   output logic       multi_err
);
   import key4_onehot_capture_pkg::*;

   logic [3:0] level;
   logic [3:0] press;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_key_debounce (
         .clk     (clk),
         .rst     (rst),
         .key_raw (key_raw[k]),
         .level   (level[k]),
         .press   (press[k])
      );
   end

   state_e     state_q,  state_d;
   logic [3:0] onehot_q, onehot_d;
   logic [1:0] code_q,   code_d;

   // Capture one event, hold it until accepted, then wait for every key to be released.
   always_comb begin
      state_d  = state_q;
      onehot_d = onehot_q;
      code_d   = code_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|press) begin
               state_d  = ST_HOLD;
               onehot_d = lowest_onehot(press);
               code_d   = onehot_to_code(lowest_onehot(press));
            end
         end
         ST_HOLD: begin
            if (ready) begin
               state_d  = ST_RELEASE;
               onehot_d = '0;
               code_d   = '0;
            end
         end
         ST_RELEASE: begin
            if (level == 4'b0000) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            onehot_d = '0;
            code_d   = '0;
         end
      endcase
   end

   // FSM and output registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         onehot_q <= '0;
         code_q   <= '0;
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
         code_q   <= code_d;
      end
   end

   assign valid  = (state_q == ST_HOLD);
   assign onehot = onehot_q;
   assign code   = code_q;

`ifdef KEY4_CAPTURE_MULTI_ERR_EN
   logic multi_err_q, multi_err_d;

   // Sticky flag: two or more keys finished debouncing to pressed on the same edge.
   always_comb begin
      multi_err_d = multi_err_q | ((press & (press - 4'd1)) != 4'd0);
   end

   // Flag register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         multi_err_q <= 1'b0;
      end else begin
         multi_err_q <= multi_err_d;
      end
   end

   assign multi_err = multi_err_q;
`else
   assign multi_err = 1'b0;
`endif

endmodule

// File: tb/tb_key4_onehot_capture.sv
// Directed and randomized checks of key4_onehot_capture against a behavioural model.
// Latency: model predicts outputs one clock edge at a time.
// Backpressure: ready driven directly by the stimulus.
module tb_key4_onehot_capture;

   localparam int D = 4;
`ifdef KEY4_CAPTURE_MULTI_ERR_EN
   localparam bit MULTI_EN = 1'b1;
`else
   localparam bit MULTI_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_raw;
   logic       ready;
   logic       valid;
   logic [3:0] onehot;
   logic [1:0] code;
   logic       multi_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Behavioural model: raw samples reach the debouncer two edges late; a key's level
   // flips once the last D synchronized samples all disagree with it.
   logic [3:0]  m_s1, m_s2, m_lvl, m_press, m_oh;
   logic        m_valid, m_release, m_multi;
   bit [255:0]  hist [4];
   int          nhist;

   key4_onehot_capture #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_raw),
      .ready     (ready),
      .valid     (valid),
      .onehot    (onehot),
      .code      (code),
      .multi_err (multi_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] code_of(input logic [3:0] oh);
      logic [31:0] c;
      c = 0;
      for (int i = 0; i < 4; i++) if (oh == (4'b0001 << i)) c = i;
      return c;
   endfunction

   task automatic model_edge();
      logic [3:0] old_press;
      logic [3:0] old_lvl;
      bit         flip;
      old_press = m_press;
      old_lvl   = m_lvl;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_oh = '0;
         m_valid = 1'b0; m_release = 1'b0; m_multi = 1'b0;
         for (int k = 0; k < 4; k++) hist[k] = '0;
         nhist = 0;
         return;
      end
      if (m_valid) begin
         if (ready) begin
            m_valid = 1'b0; m_release = 1'b1; m_oh = '0;
         end
      end else if (m_release) begin
         if (old_lvl == 4'b0000) m_release = 1'b0;
      end else if (old_press != 4'b0000) begin
         m_valid = 1'b1;
         for (int i = 3; i >= 0; i--) if (old_press[i]) m_oh = 4'b0001 << i;
      end
      if ($countones(old_press) > 1) m_multi = 1'b1;
      if (nhist < 255) nhist++;
      m_press = '0;
      for (int k = 0; k < 4; k++) begin
         hist[k] = {hist[k][254:0], m_s2[k]};
         flip = (nhist >= D);
         for (int i = 0; i < D; i++) if (hist[k][i] == old_lvl[k]) flip = 1'b0;
         if (flip) begin
            m_lvl[k]   = ~old_lvl[k];
            m_press[k] = ~old_lvl[k];
         end
      end
      m_s2 = m_s1;
      m_s1 = key_raw;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      chk("cyc_valid",  valid,  m_valid);
      chk("cyc_onehot", onehot, m_oh);
      chk("cyc_code",   code,   code_of(m_oh));
      chk("cyc_multi",  multi_err, m_multi & MULTI_EN);
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int n;
      n = 0;
      while (valid !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk(tag, valid, 1);
   endtask

   int first_v, n_v, n_stable, len;
   bit seen;

   initial begin
      rst = 1'b1; key_raw = '0; ready = 1'b0;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_oh = '0;
      m_valid = 1'b0; m_release = 1'b0; m_multi = 1'b0; nhist = 0;
      for (int k = 0; k < 4; k++) hist[k] = '0;
      tick_n(2);
      chk("rst_valid",  valid,  0);
      chk("rst_onehot", onehot, 0);
      chk("rst_code",   code,   0);
      chk("rst_multi",  multi_err, 0);
      rst = 1'b0;
      tick_n(2);

      // Single key, ready high: one-cycle pulse at the minimum latency.
      key_raw = 4'b0001; ready = 1'b1;
      first_v = 0; n_v = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (valid === 1'b1) begin
            n_v++;
            if (first_v == 0) first_v = i;
            chk("t028_onehot", onehot, 4'b0001);
            chk("t028_code",   code,   2'b00);
         end
      end
      chk("t028_latency", first_v, 2 + D + 1);
      chk("t028_pulses",  n_v, 1);
      key_raw = '0; tick_n(10);

      // One-cycle glitch must be filtered.
      key_raw = 4'b0100; tick();
      key_raw = 4'b0000;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (valid !== 1'b0 || onehot !== 4'b0000) seen = 1'b1;
      end
      chk("t029_glitch", seen, 0);

      // Held off by ready for five cycles, accepted on the sixth.
      key_raw = 4'b1000; ready = 1'b0;
      wait_valid("t030_timeout", 20);
      n_v = 0; n_stable = 0;
      for (int i = 0; i < 20 && valid === 1'b1; i++) begin
         n_v++;
         if (onehot === 4'b1000 && code === 2'b11) n_stable++;
         ready = (n_v == 6);
         tick();
      end
      chk("t030_valid_cycles", n_v, 6);
      chk("t030_stable",       n_stable, 6);
      chk("t030_dropped",      valid, 0);
      ready = 1'b0; key_raw = '0; tick_n(10);

      // Two keys debounce together: lowest index wins.
      key_raw = 4'b0110; ready = 1'b0;
      wait_valid("t031_timeout", 20);
      chk("t031_onehot", onehot, 4'b0010);
      chk("t031_code",   code,   2'b01);
      tick();
      chk("t031_multi",  multi_err, MULTI_EN);
      ready = 1'b1; tick();
      ready = 1'b0; key_raw = '0; tick_n(10);

      // Press during RELEASE is dropped; a fresh press after full release is taken.
      key_raw = 4'b0001; ready = 1'b1;
      wait_valid("t032_first", 20);
      tick();
      key_raw = 4'b0101;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (valid !== 1'b0) seen = 1'b1;
      end
      chk("t032_discard", seen, 0);
      key_raw = '0; tick_n(10);
      key_raw = 4'b0100;
      wait_valid("t032_second", 20);
      chk("t032_onehot", onehot, 4'b0100);
      chk("t032_code",   code,   2'b10);
      tick();
      key_raw = '0; tick_n(10);

      // Reset while holding an event, key kept down through reset.
      key_raw = 4'b0010; ready = 1'b0;
      wait_valid("t033_first", 20);
      rst = 1'b1; tick();
      rst = 1'b0;
      chk("t033_valid",  valid,  0);
      chk("t033_onehot", onehot, 0);
      wait_valid("t033_reemit", 2 + D + 3);
      chk("t033_onehot2", onehot, 4'b0010);
      ready = 1'b1; tick();
      ready = 1'b0; key_raw = '0; tick_n(10);

      // Randomized key patterns, ready and occasional reset.
      for (int seg = 0; seg < 80; seg++) begin
         key_raw = 4'($urandom_range(0, 15));
         len = $urandom_range(1, 14);
         for (int j = 0; j < len; j++) begin
            ready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 63) == 0);
            tick();
         end
      end
      rst = 1'b0; key_raw = '0; tick_n(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key4_onehot_capture.md
KEY4_ONEHOT_CAPTURE -- requirements
Module: key4_onehot_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable synchronized samples required to change a debounced key level (legal 2..255).
REQ-002 Parameter CNT_W, default 8, SHALL be the debounce counter width and SHALL hold DEBOUNCE_CYCLES.
REQ-003 Ports: one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 key_raw  input  4  asynchronous raw key levels, 1 = pressed.
REQ-007 ready  input  1  downstream encoder stage accepts the event.
REQ-008 valid  output  1  an event is presented on onehot/code.
REQ-009 onehot  output  4  exactly one bit set while valid, 4'b0000 otherwise; feeds the 4-to-2 encoder stage.
REQ-010 code  output  2  binary index of the set onehot bit, 2'b00 when not valid.
REQ-011 multi_err  output  1  sticky flag: more than one new press was seen in one cycle.

Function
REQ-012 Each key_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per key, a counter SHALL reset to 0 when the synchronized level equals the debounced level; otherwise it increments, and on reaching DEBOUNCE_CYCLES-1 the debounced level toggles and the counter returns to 0.
REQ-014 A press event for key k SHALL be a 0->1 transition of debounced level k; minimum latency raw edge -> valid = 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-015 FSM states IDLE, HOLD and RELEASE; reset state IDLE.
REQ-016 IDLE: on any press event, latch the lowest-index pressed key into onehot/code, assert valid, go to HOLD.
REQ-017 HOLD: valid, onehot and code SHALL remain stable until the cycle with valid&&ready; that cycle is the transfer; go to RELEASE next cycle.
REQ-018 RELEASE: valid=0; return to IDLE only once all four debounced levels are 0; new press events in RELEASE SHALL be discarded.
REQ-019 Press events occurring in HOLD SHALL be discarded, with no queueing.
REQ-020 Simultaneous press events in one cycle: the lowest index wins; multi_err SHALL set (see REQ-025).
REQ-021 ready while valid=0 SHALL have no effect.
REQ-022 The encoding rule is onehot 0001->00, 0010->01, 0100->10, 1000->11.

Reset
REQ-023 With rst=1 at a clock edge, synchronizers, debounced levels and counters SHALL clear to 0, the FSM SHALL go to IDLE, and valid=0, onehot=0000, code=00, multi_err=0 on the following cycle.
REQ-024 Reset asserted in HOLD SHALL drop valid without a transfer; keys held through reset SHALL produce a fresh event after debounce completes.

Configuration
REQ-025 With macro KEY4_CAPTURE_MULTI_ERR_EN defined, multi_err SHALL set per REQ-020 and clear only on rst; without it, multi_err SHALL be tied 0 and no detection logic SHALL be built.

Structure
REQ-026 The shared package SHALL hold the FSM state encodings (IDLE=2'd0, HOLD=2'd1, RELEASE=2'd2) and the onehot-to-code mapping constants.
REQ-027 The per-key synchronizer and debouncer SHALL be one sub-module, key_debounce, instantiated four times.

Verification
REQ-028 key_raw=0001 held for 10 cycles, ready=1 -> valid pulses exactly 1 cycle with onehot=0001 and code=00 at cycle 2+DEBOUNCE_CYCLES+1.
REQ-029 1-cycle glitch key_raw=0100 -> valid never asserts and onehot stays 0000.
REQ-030 key_raw=1000 held, ready=0 for 5 cycles then 1 -> valid, onehot=1000 and code=11 stay stable 6 cycles, transfer on cycle 6, then valid=0.
REQ-031 key_raw 0000->0110 in one cycle, held -> onehot=0010 and code=01; multi_err=1 with the macro, 0 without.
REQ-032 Key 0 held after transfer, key 2 pressed -> no event; after both are released and key 2 is pressed again -> event onehot=0100 and code=10.
REQ-033 rst pulsed in HOLD -> next cycle valid=0 and onehot=0000; a key still held re-emits after debounce.
